// File: rtl/sync_fifo_ctl_if.sv
// Streaming-side bundle of the sync_fifo_ctl buffer: write port, read port, flush and status.
// The producer/consumer pair drives through master; the FIFO itself attaches as slave.
interface sync_fifo_ctl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 6
);
   logic                  flush;
   logic                  wen;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  full;
   logic                  almost_full;
   logic                  overflow;
   logic                  ren;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;
   logic                  empty;
   logic                  almost_empty;
   logic                  underflow;
   logic [CNT_WIDTH-1:0]  count;

   modport master (
      output flush, wen, wdata, ren,
      input  full, almost_full, overflow, rdata, rvalid,
             empty, almost_empty, underflow, count
   );

   modport slave (
      input  flush, wen, wdata, ren,
      output full, almost_full, overflow, rdata, rvalid,
             empty, almost_empty, underflow, count
   );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered read, almost flags,
// sticky overflow/underflow and synchronous flush.
module sync_fifo_ctl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned AF_THRESH  = 28,
   parameter int unsigned AE_THRESH  = 4,
   parameter bit          FWFT       = 1'b1
) (
   input logic            clk,
   input logic            rst,
   sync_fifo_ctl_if.slave bus
);
   localparam int unsigned ADDR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0]  AF_CNT    = CNT_WIDTH'(AF_THRESH);
   localparam logic [CNT_WIDTH-1:0]  AE_CNT    = CNT_WIDTH'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH-1:0] raddr;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  full_q;
   logic                  empty_q;
   logic                  almost_full_q;
   logic                  almost_empty_q;
   logic                  overflow_q;
   logic                  underflow_q;

   logic                  rd_acc_c;
   logic                  wr_acc_c;
   logic [CNT_WIDTH-1:0]  count_nxt_c;

   // Accept decode; a read frees a slot so a write at full still lands.
   always_comb begin
      rd_acc_c    = bus.ren & ~empty_q & ~bus.flush;
      wr_acc_c    = bus.wen & (~full_q | rd_acc_c) & ~bus.flush;
      count_nxt_c = count_q;
      if (bus.flush) begin
         count_nxt_c = '0;
      end else if (wr_acc_c && !rd_acc_c) begin
         count_nxt_c = count_q + CNT_WIDTH'(1);
      end else if (rd_acc_c && !wr_acc_c) begin
         count_nxt_c = count_q - CNT_WIDTH'(1);
      end
   end

   // Pointers, occupancy and status flags; flags follow the registered count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr          <= '0;
         raddr          <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         count_q        <= count_nxt_c;
         full_q         <= (count_nxt_c == DEPTH_CNT);
         empty_q        <= (count_nxt_c == '0);
         almost_full_q  <= (count_nxt_c >= AF_CNT);
         almost_empty_q <= (count_nxt_c <= AE_CNT);
         if (bus.flush) begin
            waddr       <= '0;
            raddr       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
         end else begin
            if (wr_acc_c) begin
               waddr <= (waddr == LAST_ADDR) ? '0 : waddr + ADDR_WIDTH'(1);
            end
            if (rd_acc_c) begin
               raddr <= (raddr == LAST_ADDR) ? '0 : raddr + ADDR_WIDTH'(1);
            end
            overflow_q  <= overflow_q  | (bus.wen & ~wr_acc_c);
            underflow_q <= underflow_q | (bus.ren & empty_q);
         end
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_acc_c) begin
         mem[waddr] <= bus.wdata;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.rdata  = mem[raddr];
         assign bus.rvalid = ~empty_q;
      end else begin : g_reg_read
         logic [DATA_WIDTH-1:0] rdata_q;
         logic                  rvalid_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdata_q  <= '0;
               rvalid_q <= 1'b0;
            end else begin
               rvalid_q <= rd_acc_c;
               if (rd_acc_c) begin
                  rdata_q <= mem[raddr];
               end
            end
         end

         assign bus.rdata  = rdata_q;
         assign bus.rvalid = rvalid_q;
      end
   endgenerate

   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: three configurations checked against a queue-based model.
module tb_sync_fifo_ctl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sync_fifo_ctl_if #(.DATA_WIDTH(8), .CNT_WIDTH(6)) ia ();
   sync_fifo_ctl_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) ib ();
   sync_fifo_ctl_if #(.DATA_WIDTH(8), .CNT_WIDTH(6)) ic ();

   sync_fifo_ctl #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1'b1))
      dut_a (.clk(clk), .rst(rst), .bus(ia));
   sync_fifo_ctl #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b1))
      dut_b (.clk(clk), .rst(rst), .bus(ib));
   sync_fifo_ctl #(.DATA_WIDTH(8), .FIFO_DEPTH(32), .AF_THRESH(28), .AE_THRESH(4), .FWFT(1'b0))
      dut_c (.clk(clk), .rst(rst), .bus(ic));

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         sel;
   int         depth_m, af_m, ae_m;
   bit         fwft_m;
   logic [7:0] q[$];
   bit         m_ovf, m_udf, m_rvalid;
   logic [7:0] m_rdata;

   // Observed outputs of the selected instance
   int         o_count;
   logic       o_full, o_empty, o_af, o_ae, o_ovf, o_udf, o_rvalid;
   logic [7:0] o_rdata;

   task automatic select(input int s);
      sel = s;
      case (s)
         0:       begin depth_m = 32; af_m = 28; ae_m = 4; fwft_m = 1'b1; end
         1:       begin depth_m = 5;  af_m = 4;  ae_m = 1; fwft_m = 1'b1; end
         default: begin depth_m = 32; af_m = 28; ae_m = 4; fwft_m = 1'b0; end
      endcase
   endtask

   task automatic drive(input bit fl, input bit w, input logic [7:0] d, input bit r);
      case (sel)
         0:       begin ia.flush = fl; ia.wen = w; ia.wdata = d; ia.ren = r; end
         1:       begin ib.flush = fl; ib.wen = w; ib.wdata = d; ib.ren = r; end
         default: begin ic.flush = fl; ic.wen = w; ic.wdata = d; ic.ren = r; end
      endcase
   endtask

   task automatic sample();
      case (sel)
         0: begin
            o_count = int'(ia.count); o_full = ia.full; o_empty = ia.empty;
            o_af = ia.almost_full; o_ae = ia.almost_empty; o_ovf = ia.overflow;
            o_udf = ia.underflow; o_rvalid = ia.rvalid; o_rdata = ia.rdata;
         end
         1: begin
            o_count = int'(ib.count); o_full = ib.full; o_empty = ib.empty;
            o_af = ib.almost_full; o_ae = ib.almost_empty; o_ovf = ib.overflow;
            o_udf = ib.underflow; o_rvalid = ib.rvalid; o_rdata = ib.rdata;
         end
         default: begin
            o_count = int'(ic.count); o_full = ic.full; o_empty = ic.empty;
            o_af = ic.almost_full; o_ae = ic.almost_empty; o_ovf = ic.overflow;
            o_udf = ic.underflow; o_rvalid = ic.rvalid; o_rdata = ic.rdata;
         end
      endcase
   endtask

   task automatic model_clear();
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
   endtask

   // One clock: apply inputs, advance model by the FIFO rules, sample 1 time unit after the edge.
   task automatic step(input bit fl, input bit w, input logic [7:0] d, input bit r);
      int  sz;
      bit  rd, wr;
      drive(fl, w, d, r);
      @(posedge clk);
      sz = q.size();
      if (fl) begin
         q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_rvalid = 1'b0;
      end else begin
         rd = r && (sz > 0);
         wr = w && ((sz < depth_m) || rd);
         if (r && sz == 0) m_udf = 1'b1;
         if (w && !wr)     m_ovf = 1'b1;
         m_rvalid = rd;
         if (rd) m_rdata = q.pop_front();
         if (wr) q.push_back(d);
      end
      #1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      sample();
   endtask

   task automatic do_reset(input int s);
      select(s);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      sample();
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         do_reset(s);
         checks++;
         if (o_count !== 0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_ae !== 1'b1 ||
             o_af !== 1'b0 || o_ovf !== 1'b0 || o_udf !== 1'b0 || o_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags inst=%0d: count=%0d empty=%b full=%b ae=%b af=%b ovf=%b udf=%b rvalid=%b, required 0 1 0 1 0 0 0 0",
                     s, o_count, o_empty, o_full, o_ae, o_af, o_ovf, o_udf, o_rvalid);
         end
      end
      checks++;
      if (o_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_rdata: got %h, required 00", o_rdata);
      end
   endtask

   task automatic test_fill_drain();
      do_reset(0);
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0);
         checks++;
         if (o_count !== i + 1 || o_af !== (i + 1 >= 28) || o_full !== (i == 31)) begin
            errors++;
            $display("FAIL fill_%0d: count=%0d af=%b full=%b, required %0d %b %b",
                     i, o_count, o_af, o_full, i + 1, (i + 1 >= 28), (i == 31));
         end
      end
      step(1'b0, 1'b1, 8'hEE, 1'b0);
      checks++;
      if (o_ovf !== 1'b1 || o_count !== 32) begin
         errors++;
         $display("FAIL overflow_at_full: ovf=%b count=%0d, required 1 32", o_ovf, o_count);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (o_rdata !== 8'(i)) begin
            errors++;
            $display("FAIL drain_data_%0d: got %h, required %h", i, o_rdata, 8'(i));
         end
         step(1'b0, 1'b0, 8'h00, 1'b1);
      end
      checks++;
      if (o_empty !== 1'b1 || o_count !== 0 || o_udf !== 1'b0) begin
         errors++;
         $display("FAIL drained: empty=%b count=%0d udf=%b, required 1 0 0", o_empty, o_count, o_udf);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (o_udf !== 1'b1 || o_count !== 0) begin
         errors++;
         $display("FAIL underflow: udf=%b count=%0d, required 1 0", o_udf, o_count);
      end
   endtask

   task automatic test_full_rw();
      do_reset(0);
      for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 127)), 1'b0);
      step(1'b0, 1'b1, 8'hAA, 1'b1);
      checks++;
      if (o_count !== 32 || o_full !== 1'b1 || o_ovf !== 1'b0) begin
         errors++;
         $display("FAIL full_rw: count=%0d full=%b ovf=%b, required 32 1 0", o_count, o_full, o_ovf);
      end
      for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (o_rdata !== 8'hAA || o_count !== 1) begin
         errors++;
         $display("FAIL full_rw_data: rdata=%h count=%0d, required aa 1", o_rdata, o_count);
      end
   endtask

   task automatic test_registered_read();
      do_reset(2);
      step(1'b0, 1'b1, 8'h11, 1'b0);
      step(1'b0, 1'b1, 8'h22, 1'b0);
      checks++;
      if (o_rvalid !== 1'b0 || o_rdata !== 8'h00) begin
         errors++;
         $display("FAIL regread_idle: rvalid=%b rdata=%h, required 0 00", o_rvalid, o_rdata);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (o_rvalid !== 1'b1 || o_rdata !== 8'h11) begin
         errors++;
         $display("FAIL regread_first: rvalid=%b rdata=%h, required 1 11", o_rvalid, o_rdata);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (o_rvalid !== 1'b1 || o_rdata !== 8'h22) begin
         errors++;
         $display("FAIL regread_second: rvalid=%b rdata=%h, required 1 22", o_rvalid, o_rdata);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (o_rvalid !== 1'b0 || o_rdata !== 8'h22 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL regread_hold: rvalid=%b rdata=%h empty=%b, required 0 22 1", o_rvalid, o_rdata, o_empty);
      end
   endtask

   task automatic test_flush();
      do_reset(0);
      for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
      checks++;
      if (o_count !== 10 || o_ovf !== 1'b1) begin
         errors++;
         $display("FAIL pre_flush: count=%0d ovf=%b, required 10 1", o_count, o_ovf);
      end
      step(1'b1, 1'b1, 8'h55, 1'b0);
      checks++;
      if (o_count !== 0 || o_empty !== 1'b1 || o_ovf !== 1'b0 || o_ae !== 1'b1) begin
         errors++;
         $display("FAIL flush: count=%0d empty=%b ovf=%b ae=%b, required 0 1 0 1", o_count, o_empty, o_ovf, o_ae);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);
      checks++;
      if (o_count !== 0 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL flush_no_write: count=%0d empty=%b, required 0 1", o_count, o_empty);
      end
   endtask

   task automatic test_async_reset();
      do_reset(2);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      sample();
      checks++;
      if (o_count !== 0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_ae !== 1'b1 || o_af !== 1'b0 ||
          o_ovf !== 1'b0 || o_udf !== 1'b0 || o_rvalid !== 1'b0 || o_rdata !== 8'h00) begin
         errors++;
         $display("FAIL async_reset: count=%0d empty=%b full=%b ae=%b af=%b ovf=%b udf=%b rvalid=%b rdata=%h, required 0 1 0 1 0 0 0 0 00",
                  o_count, o_empty, o_full, o_ae, o_af, o_ovf, o_udf, o_rvalid, o_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   // Random traffic with phases biased toward filling and draining.
   task automatic test_random(input int s, input int n, input int flush_pct);
      int   wp;
      bit   fl, w, r;
      bit   exp_rvalid;
      logic [7:0] exp_rdata;
      do_reset(s);
      for (int c = 0; c < n; c++) begin
         wp = ((c / 40) % 2 == 0) ? 80 : 25;
         fl = ($urandom_range(0, 99) < flush_pct);
         w  = ($urandom_range(0, 99) < wp);
         r  = ($urandom_range(0, 99) < 50);
         step(fl, w, 8'($urandom), r);
         exp_rvalid = fwft_m ? (q.size() > 0) : m_rvalid;
         exp_rdata  = (fwft_m && q.size() > 0) ? q[0] : m_rdata;
         checks++;
         if (o_count !== q.size() || o_full !== (q.size() == depth_m) || o_empty !== (q.size() == 0) ||
             o_af !== (q.size() >= af_m) || o_ae !== (q.size() <= ae_m) ||
             o_ovf !== m_ovf || o_udf !== m_udf || o_rvalid !== exp_rvalid || o_count > depth_m) begin
            errors++;
            $display("FAIL random_flags inst=%0d cyc=%0d: count=%0d full=%b empty=%b af=%b ae=%b ovf=%b udf=%b rvalid=%b, required %0d %b %b %b %b %b %b %b",
                     s, c, o_count, o_full, o_empty, o_af, o_ae, o_ovf, o_udf, o_rvalid,
                     q.size(), (q.size() == depth_m), (q.size() == 0), (q.size() >= af_m),
                     (q.size() <= ae_m), m_ovf, m_udf, exp_rvalid);
         end
         if (exp_rvalid) begin
            checks++;
            if (o_rdata !== exp_rdata) begin
               errors++;
               $display("FAIL random_data inst=%0d cyc=%0d: got %h, required %h", s, c, o_rdata, exp_rdata);
            end
         end
      end
   endtask

   initial begin
      ia.flush = 1'b0; ia.wen = 1'b0; ia.wdata = 8'h00; ia.ren = 1'b0;
      ib.flush = 1'b0; ib.wen = 1'b0; ib.wdata = 8'h00; ib.ren = 1'b0;
      ic.flush = 1'b0; ic.wen = 1'b0; ic.wdata = 8'h00; ic.ren = 1'b0;
      test_reset();
      test_fill_drain();
      test_full_rw();
      test_registered_read();
      test_flush();
      test_async_reset();
      test_random(1, 300, 0);
      test_random(0, 600, 1);
      test_random(2, 600, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
